// File: rtl/collision_scanner.sv
// Per-frame collision scanner: walks every wall once per start request and reports the first hit.
// Also keeps a saturating count of walls the bird has fully passed.
module collision_scanner #(
    parameter int unsigned COORD_W   = 8,
    parameter int unsigned NUM_WALLS = 4,
    parameter int unsigned IDX_W     = 2,
    parameter int unsigned SCORE_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               clear_score,
    input  logic [COORD_W-1:0] bird_xleft,
    input  logic [COORD_W-1:0] bird_xright,
    input  logic [COORD_W-1:0] bird_ytop,
    input  logic [COORD_W-1:0] bird_ybottom,
    output logic [IDX_W-1:0]   wall_idx,
    input  logic [COORD_W-1:0] wall_xleft,
    input  logic [COORD_W-1:0] wall_xright,
    input  logic [COORD_W-1:0] wall_topy,
    input  logic [COORD_W-1:0] wall_bottomy,
    output logic               busy,
    output logic               done,
    output logic               touched,
    output logic [IDX_W-1:0]   hit_idx,
    output logic [SCORE_W-1:0] score
);

    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_WALLS - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [COORD_W-1:0]   lat_xleft, lat_xright, lat_ytop, lat_ybottom;
    logic                 acc_hit;
    logic [IDX_W-1:0]     acc_idx;
    logic [NUM_WALLS-1:0] passed;

    logic last_wall, wall_hit, wall_beyond, score_inc;

    // Per-wall geometry against the latched bird box
    always_comb begin
        last_wall   = (wall_idx == LAST_IDX);
        wall_hit    = (lat_xright >= wall_xleft) && (lat_xleft <= wall_xright)
                      && ((lat_ytop <= wall_topy) || (lat_ybottom >= wall_bottomy));
        wall_beyond = (lat_xleft > wall_xright);
        score_inc   = (state == SCAN) && wall_beyond && !passed[wall_idx];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SCAN;
            SCAN:    if (last_wall) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Scan datapath and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            wall_idx    <= '0;
            lat_xleft   <= '0;
            lat_xright  <= '0;
            lat_ytop    <= '0;
            lat_ybottom <= '0;
            acc_hit     <= 1'b0;
            acc_idx     <= '0;
            touched     <= 1'b0;
            hit_idx     <= '0;
        end else begin
            busy     <= (state_next == SCAN);
            done     <= (state_next == DONE);
            wall_idx <= (state == SCAN && !last_wall) ? wall_idx + IDX_W'(1) : '0;
            if (state == IDLE && start) begin
                lat_xleft   <= bird_xleft;
                lat_xright  <= bird_xright;
                lat_ytop    <= bird_ytop;
                lat_ybottom <= bird_ybottom;
                acc_hit     <= 1'b0;
                acc_idx     <= '0;
            end
            if (state == SCAN) begin
                if (wall_hit && !acc_hit) begin
                    acc_hit <= 1'b1;
                    acc_idx <= wall_idx;
                end
                // Results land together with the done pulse, folding in the final wall
                if (last_wall) begin
                    touched <= acc_hit || wall_hit;
                    hit_idx <= acc_hit ? acc_idx : (wall_hit ? wall_idx : '0);
                end
            end
        end
    end

    // Passed flags re-arm once a wall is recycled to the right of the bird
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            passed <= '0;
        end else if (state == SCAN) begin
            passed[wall_idx] <= wall_beyond;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                               score <= '0;
        else if (clear_score)                    score <= '0;
        else if (score_inc && score != SCORE_MAX) score <= score + SCORE_W'(1);
    end

endmodule

// File: tb/tb_collision_scanner.sv
// Directed bench for collision_scanner: wall table model, hand-computed expectations.
module tb_collision_scanner;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       clear_score;
    logic [7:0] bird_xleft, bird_xright, bird_ytop, bird_ybottom;
    logic [1:0] wall_idx;
    logic [7:0] wall_xleft, wall_xright, wall_topy, wall_bottomy;
    logic       busy, done, touched;
    logic [1:0] hit_idx;
    logic [7:0] score;

    logic [7:0] wxl [4];
    logic [7:0] wxr [4];
    logic [7:0] wty [4];
    logic [7:0] wby [4];

    int checks = 0;
    int errors = 0;

    collision_scanner dut (
        .clk(clk), .reset(reset), .start(start), .clear_score(clear_score),
        .bird_xleft(bird_xleft), .bird_xright(bird_xright),
        .bird_ytop(bird_ytop), .bird_ybottom(bird_ybottom),
        .wall_idx(wall_idx),
        .wall_xleft(wall_xleft), .wall_xright(wall_xright),
        .wall_topy(wall_topy), .wall_bottomy(wall_bottomy),
        .busy(busy), .done(done), .touched(touched), .hit_idx(hit_idx), .score(score)
    );

    always #5 clk = ~clk;

    always_comb begin
        wall_xleft   = wxl[wall_idx];
        wall_xright  = wxr[wall_idx];
        wall_topy    = wty[wall_idx];
        wall_bottomy = wby[wall_idx];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_wall(input int i, input logic [7:0] xl, input logic [7:0] xr,
                            input logic [7:0] ty, input logic [7:0] by);
        wxl[i] = xl; wxr[i] = xr; wty[i] = ty; wby[i] = by;
    endtask

    task automatic far_wall(input int i);
        set_wall(i, 8'd200, 8'd210, 8'd0, 8'd255);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full scan; bird inputs are scrambled after start so only latched values may matter
    task automatic run_scan(input logic [7:0] xl, input logic [7:0] xr,
                            input logic [7:0] yt, input logic [7:0] yb, input bit clr_first);
        int n;
        bird_xleft = xl; bird_xright = xr; bird_ytop = yt; bird_ybottom = yb;
        start = 1'b1;
        tick();
        start = 1'b0;
        bird_xleft = 8'd0; bird_xright = 8'd255; bird_ytop = 8'd0; bird_ybottom = 8'd255;
        if (clr_first) clear_score = 1'b1;
        n = 0;
        while (!done && n < 20) begin
            check("busy", 32'(busy), 32'd1);
            check("wall_idx", 32'(wall_idx), 32'(n));
            tick();
            clear_score = 1'b0;
            n++;
        end
        check("latency", 32'(n), 32'd4);
        check("busy_at_done", 32'(busy), 32'd0);
        check("wall_idx_at_done", 32'(wall_idx), 32'd0);
        tick();
        check("done_pulse", 32'(done), 32'd0);
    endtask

    task automatic scan_std(input bit clr_first);
        run_scan(8'd10, 8'd17, 8'd50, 8'd57, clr_first);
    endtask

    initial begin
        int cnt;
        int exp_score;
        reset = 1'b1; start = 1'b0; clear_score = 1'b0;
        bird_xleft = '0; bird_xright = '0; bird_ytop = '0; bird_ybottom = '0;
        set_wall(0, 8'd40, 8'd50, 8'd30, 8'd80);
        for (int i = 1; i < 4; i++) far_wall(i);
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_touched", 32'(touched), 32'd0);
        check("rst_hit_idx", 32'(hit_idx), 32'd0);
        check("rst_score", 32'(score), 32'd0);
        check("rst_wall_idx", 32'(wall_idx), 32'd0);
        reset = 1'b0;

        // Basic miss
        scan_std(1'b0);
        check("miss_touched", 32'(touched), 32'd0);
        check("miss_hit_idx", 32'(hit_idx), 32'd0);
        check("miss_score", 32'(score), 32'd0);

        // Hit on wall2 via top edge, then lower index wall1 also hits
        set_wall(2, 8'd12, 8'd20, 8'd55, 8'd90);
        scan_std(1'b0);
        check("hit2_touched", 32'(touched), 32'd1);
        check("hit2_idx", 32'(hit_idx), 32'd2);
        set_wall(1, 8'd12, 8'd20, 8'd55, 8'd90);
        scan_std(1'b0);
        check("hit1_touched", 32'(touched), 32'd1);
        check("hit1_idx", 32'(hit_idx), 32'd1);
        check("hit1_score", 32'(score), 32'd0);
        far_wall(1);

        // Passing and re-arming wall0 (wall2 keeps hitting)
        set_wall(0, 8'd0, 8'd9, 8'd30, 8'd80);
        scan_std(1'b0);
        check("pass1_score", 32'(score), 32'd1);
        check("pass1_touched", 32'(touched), 32'd1);
        check("pass1_hit_idx", 32'(hit_idx), 32'd2);
        scan_std(1'b0);
        check("pass2_score", 32'(score), 32'd1);
        scan_std(1'b0);
        check("pass3_score", 32'(score), 32'd1);
        set_wall(0, 8'd100, 8'd110, 8'd30, 8'd80);
        scan_std(1'b0);
        check("recycle_score", 32'(score), 32'd1);
        set_wall(0, 8'd0, 8'd9, 8'd30, 8'd80);
        scan_std(1'b0);
        check("repass_score", 32'(score), 32'd2);

        // Start during SCAN and during DONE is ignored
        bird_xleft = 8'd10; bird_xright = 8'd17; bird_ytop = 8'd50; bird_ybottom = 8'd57;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (done) begin
                cnt++;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        check("one_done", 32'(cnt), 32'd1);
        check("restart_busy", 32'(busy), 32'd0);
        check("restart_score", 32'(score), 32'd2);
        check("restart_hit_idx", 32'(hit_idx), 32'd2);

        // Reset mid-scan
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_touched", 32'(touched), 32'd0);
        check("mid_rst_hit_idx", 32'(hit_idx), 32'd0);
        check("mid_rst_score", 32'(score), 32'd0);
        check("mid_rst_wall_idx", 32'(wall_idx), 32'd0);
        tick();
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) cnt++;
            tick();
        end
        check("no_done_after_rst", 32'(cnt), 32'd0);
        scan_std(1'b0);
        check("flags_cleared_score", 32'(score), 32'd1);
        check("post_rst_hit_idx", 32'(hit_idx), 32'd2);

        // Inclusive boundaries
        far_wall(2);
        set_wall(0, 8'd17, 8'd30, 8'd20, 8'd57);
        scan_std(1'b0);
        check("edge_bottom_touched", 32'(touched), 32'd1);
        check("edge_bottom_idx", 32'(hit_idx), 32'd0);
        set_wall(0, 8'd18, 8'd30, 8'd20, 8'd57);
        scan_std(1'b0);
        check("edge_xgap_touched", 32'(touched), 32'd0);
        set_wall(0, 8'd17, 8'd30, 8'd50, 8'd90);
        scan_std(1'b0);
        check("edge_top_touched", 32'(touched), 32'd1);
        set_wall(0, 8'd17, 8'd30, 8'd49, 8'd58);
        scan_std(1'b0);
        check("inside_hole_touched", 32'(touched), 32'd0);

        // Saturation and clear priority
        clear_score = 1'b1;
        tick();
        clear_score = 1'b0;
        check("clear_idle", 32'(score), 32'd0);
        exp_score = 0;
        for (int it = 0; it < 64; it++) begin
            for (int i = 0; i < 4; i++) set_wall(i, 8'd0, 8'd9, 8'd0, 8'd255);
            scan_std(1'b0);
            exp_score = (exp_score + 4 > 255) ? 255 : exp_score + 4;
            if (it == 0) check("four_passes", 32'(score), 32'(exp_score));
            for (int i = 0; i < 4; i++) far_wall(i);
            scan_std(1'b0);
        end
        check("sat_reach", 32'(score), 32'(exp_score));
        set_wall(0, 8'd0, 8'd9, 8'd0, 8'd255);
        scan_std(1'b0);
        check("sat_hold", 32'(score), 32'd255);
        far_wall(0);
        scan_std(1'b0);
        set_wall(0, 8'd0, 8'd9, 8'd0, 8'd255);
        scan_std(1'b1);
        check("clear_beats_inc", 32'(score), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
